// File: rtl/inst_fetch_pkg.sv
// Shared constants and state encoding for the IF-stage fetch engine.
// Mirrors the pipeline-wide config values the fetch logic depends on.
package inst_fetch_pkg;

    localparam int   ADDR_LEN     = 32;
    localparam int   INST_LEN     = 32;
    localparam logic RESET_ENABLE = 1'b1;
    localparam logic NO_STOP      = 1'b0;
    localparam int   IF_STALL_BIT = 1;

    typedef enum logic [1:0] {
        IF_LOAD  = 2'b00,
        IF_FETCH = 2'b01,
        IF_DONE  = 2'b10
    } if_state_e;

endpackage

// File: rtl/inst_fetch.sv
// IF-stage fetch engine: reads one instruction as little-endian byte reads
// from a byte-wide memory controller and hands {inst, pc} to IF/ID.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_LEN,
    parameter int INST_W = INST_LEN,
    parameter int NBYTES = INST_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              jump_i,
    input  logic [5:0]        stall_i,
    output logic              stall_req_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_rvalid_i,
    input  logic [7:0]        mem_data_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o
);

    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int BUF_W = INST_W - 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    if_state_e         r_state;
    if_state_e         w_nextState;
    logic [ADDR_W-1:0] r_base;
    logic [IDX_W-1:0]  r_idx;
    logic [BUF_W-1:0]  r_buf;
    logic              w_stallIf;
    logic              w_lastByte;
    logic              w_unusedStall;

    assign w_stallIf     = stall_i[IF_STALL_BIT];
    assign w_unusedStall = ^{stall_i[5:2], stall_i[0]};
    assign w_lastByte    = mem_rvalid_i && (r_idx == LAST_IDX);

    assign mem_req_o   = (r_state == IF_FETCH);
    assign stall_req_o = (r_state != IF_DONE);
    assign mem_addr_o  = r_base + ADDR_W'(r_idx);

    always_ff @(posedge clk) begin
        if (rst == RESET_ENABLE) begin
            r_state <= IF_LOAD;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A redirect always wins; otherwise LOAD -> FETCH -> DONE -> LOAD.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IF_LOAD:  w_nextState = IF_FETCH;
            IF_FETCH: if (w_lastByte) w_nextState = IF_DONE;
            IF_DONE:  if (w_stallIf == NO_STOP) w_nextState = IF_LOAD;
            default:  w_nextState = IF_LOAD;
        endcase
        if (jump_i) begin
            w_nextState = IF_LOAD;
        end
    end

    // Bytes shift in from the top so the oldest byte ends up lowest (little-endian).
    always_ff @(posedge clk) begin
        if (rst == RESET_ENABLE) begin
            r_base       <= '0;
            r_idx        <= '0;
            r_buf        <= '0;
            inst_o       <= '0;
            inst_pc_o    <= '0;
            inst_valid_o <= 1'b0;
        end else if (jump_i) begin
            r_idx        <= '0;
            inst_valid_o <= 1'b0;
        end else begin
            case (r_state)
                IF_LOAD: begin
                    r_base <= pc_i;
                    r_idx  <= '0;
                end
                IF_FETCH: begin
                    if (mem_rvalid_i) begin
                        r_idx <= r_idx + IDX_W'(1);
                        if (w_lastByte) begin
                            inst_o       <= {mem_data_i, r_buf};
                            inst_pc_o    <= r_base;
                            inst_valid_o <= 1'b1;
                        end else begin
                            r_buf <= {mem_data_i, r_buf[BUF_W-1:8]};
                        end
                    end
                end
                IF_DONE: begin
                    if (w_stallIf == NO_STOP) begin
                        inst_valid_o <= 1'b0;
                        r_idx        <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: table of fetch vectors with a
// scoreboard of expected {inst, pc}, plus hand sequences for abort/reset.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_i = '0;
    logic        jump_i = 1'b0;
    logic [5:0]  stall_i = '0;
    logic        stall_req_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_rvalid_i = 1'b0;
    logic [7:0]  mem_data_i = '0;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } sb_t;

    typedef struct {
        logic [31:0] pc;
        int          gap0;
        int          gap1;
        int          gap2;
        int          gap3;
        int          hold;
        bit          jumpEnd;
        logic [31:0] jumpPc;
        bit          stray;
        logic [31:0] expInst;
    } vec_t;

    sb_t  sbQueue[$];
    vec_t vecs[7];
    logic prevValid = 1'b0;

    inst_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .jump_i       (jump_i),
        .stall_i      (stall_i),
        .stall_req_o  (stall_req_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_data_i   (mem_data_i),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_valid_o (inst_valid_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [7:0] memByte(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 8'h13;
            32'h0000_0001: return 8'h05;
            32'h0000_0002: return 8'h10;
            32'h0000_0003: return 8'h00;
            32'h0000_0004: return 8'h93;
            32'h0000_0005: return 8'h05;
            32'h0000_0006: return 8'h20;
            32'h0000_0007: return 8'h00;
            32'h0000_0100: return 8'h13;
            32'h0000_0101: return 8'h06;
            32'h0000_0102: return 8'h30;
            32'h0000_0103: return 8'h00;
            32'hFFFF_FFFE: return 8'hAA;
            32'hFFFF_FFFF: return 8'hBB;
            default:       return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: pop one expected instruction on each rising edge of valid.
    always @(negedge clk) begin
        if (inst_valid_o && !prevValid) begin
            if (sbQueue.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_unexpected: got valid inst %h expected none", inst_o);
            end else begin
                sb_t e;
                e = sbQueue.pop_front();
                checkOutput("sb_inst", inst_o, e.inst);
                checkOutput("sb_pc", inst_pc_o, e.pc);
            end
        end
        prevValid = inst_valid_o;
    end

    // Entered and left at a negedge with the DUT in LOAD.
    task automatic applyStimulus(input vec_t v);
        int g[4];
        logic [31:0] a;
        g = '{v.gap0, v.gap1, v.gap2, v.gap3};
        pc_i = v.pc;
        jump_i = 1'b0;
        stall_i = '0;
        mem_rvalid_i = v.stray;
        mem_data_i = v.stray ? 8'hEE : 8'h00;
        sbQueue.push_back('{inst: v.expInst, pc: v.pc});
        checkOutput("load_stallreq", 32'(stall_req_o), 32'd1);
        checkOutput("load_req", 32'(mem_req_o), 32'd0);
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a = v.pc + 32'(k);
            for (int w = 0; w < g[k]; w++) begin
                checkOutput("gap_req", 32'(mem_req_o), 32'd1);
                checkOutput("gap_addr", mem_addr_o, a);
                @(negedge clk);
            end
            checkOutput("fetch_addr", mem_addr_o, a);
            checkOutput("fetch_req", 32'(mem_req_o), 32'd1);
            checkOutput("fetch_stallreq", 32'(stall_req_o), 32'd1);
            checkOutput("fetch_valid", 32'(inst_valid_o), 32'd0);
            mem_rvalid_i = 1'b1;
            mem_data_i = memByte(a);
            @(negedge clk);
            mem_rvalid_i = 1'b0;
        end
        checkOutput("done_valid", 32'(inst_valid_o), 32'd1);
        checkOutput("done_stallreq", 32'(stall_req_o), 32'd0);
        checkOutput("done_req", 32'(mem_req_o), 32'd0);
        checkOutput("done_inst", inst_o, v.expInst);
        checkOutput("done_pc", inst_pc_o, v.pc);
        if (v.hold > 0) begin
            stall_i = 6'b000010;
            for (int h = 0; h < v.hold; h++) begin
                @(negedge clk);
                checkOutput("hold_valid", 32'(inst_valid_o), 32'd1);
                checkOutput("hold_inst", inst_o, v.expInst);
                checkOutput("hold_pc", inst_pc_o, v.pc);
                checkOutput("hold_req", 32'(mem_req_o), 32'd0);
            end
        end
        if (v.jumpEnd) begin
            jump_i = 1'b1;
            pc_i = v.jumpPc;
        end else begin
            stall_i = '0;
        end
        @(negedge clk);
        jump_i = 1'b0;
        stall_i = '0;
        checkOutput("next_valid", 32'(inst_valid_o), 32'd0);
        checkOutput("next_stallreq", 32'(stall_req_o), 32'd1);
        checkOutput("next_req", 32'(mem_req_o), 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, 0, 0, 0, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0010_0513};
        vecs[1] = '{32'h0000_0000, 0, 3, 1, 2, 0, 1'b0, 32'h0, 1'b0, 32'h0010_0513};
        vecs[2] = '{32'h0000_0000, 0, 0, 0, 0, 3, 1'b0, 32'h0, 1'b0, 32'h0010_0513};
        vecs[3] = '{32'h0000_0004, 0, 0, 0, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0020_0593};
        vecs[4] = '{32'h0000_0004, 0, 0, 0, 0, 2, 1'b1, 32'h100, 1'b0, 32'h0020_0593};
        vecs[5] = '{32'h0000_0100, 0, 0, 0, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0030_0613};
        vecs[6] = '{32'hFFFF_FFFE, 1, 0, 0, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0513_BBAA};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_req", 32'(mem_req_o), 32'd0);
        checkOutput("rst_addr", mem_addr_o, 32'h0);
        checkOutput("rst_inst", inst_o, 32'h0);
        checkOutput("rst_pc", inst_pc_o, 32'h0);
        checkOutput("rst_valid", 32'(inst_valid_o), 32'd0);
        checkOutput("rst_stallreq", 32'(stall_req_o), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i]);
        end

        // Redirect after two bytes; the stray rvalid in LOAD must not count.
        pc_i = 32'h0;
        @(negedge clk);
        checkOutput("abort_addr0", mem_addr_o, 32'h0);
        mem_rvalid_i = 1'b1;
        mem_data_i = memByte(32'h0);
        @(negedge clk);
        checkOutput("abort_addr1", mem_addr_o, 32'h1);
        mem_data_i = memByte(32'h1);
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        checkOutput("abort_addr2", mem_addr_o, 32'h2);
        jump_i = 1'b1;
        pc_i = 32'h100;
        @(negedge clk);
        jump_i = 1'b0;
        checkOutput("abort_req", 32'(mem_req_o), 32'd0);
        checkOutput("abort_valid", 32'(inst_valid_o), 32'd0);
        checkOutput("abort_stallreq", 32'(stall_req_o), 32'd1);
        begin
            vec_t sv;
            sv = vecs[5];
            sv.stray = 1'b1;
            applyStimulus(sv);
        end

        for (int i = 4; i < 7; i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset in the middle of a wrapping fetch.
        pc_i = 32'hFFFF_FFFE;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            mem_rvalid_i = 1'b1;
            mem_data_i = memByte(mem_addr_o);
            @(negedge clk);
        end
        checkOutput("wrap_addr", mem_addr_o, 32'h0);
        rst = 1'b1;
        mem_data_i = memByte(32'h0);
        @(negedge clk);
        checkOutput("midrst_req", 32'(mem_req_o), 32'd0);
        checkOutput("midrst_addr", mem_addr_o, 32'h0);
        checkOutput("midrst_inst", inst_o, 32'h0);
        checkOutput("midrst_pc", inst_pc_o, 32'h0);
        checkOutput("midrst_valid", 32'(inst_valid_o), 32'd0);
        checkOutput("midrst_stallreq", 32'(stall_req_o), 32'd1);
        rst = 1'b0;
        mem_rvalid_i = 1'b0;
        @(negedge clk);

        checkOutput("sb_empty", 32'(sbQueue.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
